// File: rtl/multi_vc_input_channel.sv
// Multi-VC router input channel: per-VC FIFOs, XY routing computed on the head flit,
// and round-robin output arbitration that keeps each packet together on the output.
module multi_vc_input_channel #(
    parameter int NUM_VC    = 2,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 32,
    parameter int COORD_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        pos_x,
    input  logic [COORD_W-1:0]        pos_y,
    input  logic                      in_valid,
    input  logic [$clog2(NUM_VC)-1:0] in_vc,
    input  logic [1:0]                in_tag,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    output logic [NUM_VC-1:0]         in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM_VC)-1:0] out_vc,
    output logic [1:0]                out_tag,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [2:0]                out_target,
    output logic                      out_last,
    output logic [7:0]                err_count
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [VC_W:0]   VC_LIMIT = (VC_W+1)'(NUM_VC);
    localparam logic [VC_W-1:0] VC_LAST  = VC_W'(NUM_VC - 1);

    localparam logic [1:0] TAG_START = 2'd0;
    localparam logic [1:0] TAG_TAIL  = 2'd2;
    localparam logic [1:0] TAG_SAE   = 2'd3;

    localparam logic [2:0] TGT_LOCAL = 3'd0;
    localparam logic [2:0] TGT_EAST  = 3'd1;
    localparam logic [2:0] TGT_WEST  = 3'd2;
    localparam logic [2:0] TGT_NORTH = 3'd3;
    localparam logic [2:0] TGT_SOUTH = 3'd4;

    function automatic logic [2:0] route(input logic [COORD_W-1:0] dx,
                                         input logic [COORD_W-1:0] dy,
                                         input logic [COORD_W-1:0] px,
                                         input logic [COORD_W-1:0] py);
        if (dx > px)      return TGT_EAST;
        else if (dx < px) return TGT_WEST;
        else if (dy > py) return TGT_NORTH;
        else if (dy < py) return TGT_SOUTH;
        return TGT_LOCAL;
    endfunction

    logic [1:0]           tag_mem_q [NUM_VC][DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem_q [NUM_VC][DEPTH];
    logic [2:0]           tgt_mem_q [NUM_VC][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q  [NUM_VC];
    logic [PTR_W-1:0]     rd_ptr_q  [NUM_VC];
    logic [PTR_W:0]       count_q   [NUM_VC];
    logic [2:0]           route_q   [NUM_VC];
    logic [NUM_VC-1:0]    open_q;

    logic                 lock_q, lock_d;
    logic [VC_W-1:0]      lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]      rr_last_q, rr_last_d;
    logic [7:0]           err_q, err_d;

    logic [NUM_VC-1:0]    not_full, not_empty;
    logic                 vc_ok, in_acc, in_head, in_bad, in_enq;
    logic [2:0]           in_tgt;
    logic [VC_W-1:0]      rr_vc, cand, grant_vc;
    logic                 rr_found, out_fire, same_vc;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_status
        assign not_full[v]  = (count_q[v] != FULL_CNT);
        assign not_empty[v] = (count_q[v] != '0);
    end

    // Input side: ready comes only from registered occupancy.
    assign in_ready = rst ? '0 : not_full;
    assign vc_ok    = ({1'b0, in_vc} < VC_LIMIT);
    assign in_acc   = in_valid && vc_ok && in_ready[in_vc];
    assign in_head  = (in_tag == TAG_START) || (in_tag == TAG_SAE);
    // A head on an open VC or a body/tail on a closed VC is malformed.
    assign in_bad   = (in_head == open_q[in_vc]);
    assign in_enq   = in_acc && !in_bad;
    assign in_tgt   = in_head ? route(in_payload[COORD_W-1:0], in_payload[2*COORD_W-1:COORD_W],
                                      pos_x, pos_y)
                              : route_q[in_vc];

    // Output side: round-robin pick, overridden by the VC that currently owns the output.
    always_comb begin
        rr_vc    = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            cand = VC_W'((int'(rr_last_q) + i) % NUM_VC);
            if (!rr_found && not_empty[cand]) begin
                rr_vc    = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign grant_vc    = lock_q ? lock_vc_q : rr_vc;
    assign out_valid   = lock_q ? not_empty[lock_vc_q] : rr_found;
    assign out_vc      = grant_vc;
    assign out_tag     = tag_mem_q[grant_vc][rd_ptr_q[grant_vc]];
    assign out_payload = pay_mem_q[grant_vc][rd_ptr_q[grant_vc]];
    assign out_target  = tgt_mem_q[grant_vc][rd_ptr_q[grant_vc]];
    assign out_last    = (out_tag == TAG_TAIL) || (out_tag == TAG_SAE);
    assign out_fire    = out_valid && out_ready;
    assign same_vc     = in_enq && out_fire && (in_vc == grant_vc);
    assign err_count   = err_q;

    // The output is held by a VC from the first cycle a flit is offered (keeps the
    // offered flit stable under backpressure) until its last flit transfers.
    always_comb begin
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        rr_last_d = rr_last_q;
        err_d     = err_q;
        if (out_fire) rr_last_d = grant_vc;
        if (out_fire && out_last) begin
            lock_d = 1'b0;
        end else if (out_valid) begin
            lock_d    = 1'b1;
            lock_vc_d = grant_vc;
        end
        if (in_acc && in_bad && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            rr_last_q <= VC_LAST;
            err_q     <= '0;
            wr_ptr_q  <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
            count_q   <= '{default: '0};
            route_q   <= '{default: '0};
            open_q    <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
            if (in_enq) begin
                wr_ptr_q[in_vc] <= wr_ptr_q[in_vc] + 1'b1;
                if (!same_vc) count_q[in_vc] <= count_q[in_vc] + 1'b1;
                if (in_head) route_q[in_vc] <= in_tgt;
                if (in_tag == TAG_START)     open_q[in_vc] <= 1'b1;
                else if (in_tag == TAG_TAIL) open_q[in_vc] <= 1'b0;
            end
            if (out_fire) begin
                rd_ptr_q[grant_vc] <= rd_ptr_q[grant_vc] + 1'b1;
                if (!same_vc) count_q[grant_vc] <= count_q[grant_vc] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_enq) begin
            tag_mem_q[in_vc][wr_ptr_q[in_vc]] <= in_tag;
            pay_mem_q[in_vc][wr_ptr_q[in_vc]] <= in_payload;
            tgt_mem_q[in_vc][wr_ptr_q[in_vc]] <= in_tgt;
        end
    end

endmodule

// File: tb/tb_multi_vc_input_channel.sv
// Bench for multi_vc_input_channel: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multi_vc_input_channel;
    localparam int NV    = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int CW    = 4;
    localparam int VW    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] pos_x = 4'd2, pos_y = 4'd2;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_vc = '0;
    logic [1:0]    in_tag = 2'd0;
    logic [PW-1:0] in_payload = '0;
    logic [NV-1:0] in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_vc;
    logic [1:0]    out_tag;
    logic [PW-1:0] out_payload;
    logic [2:0]    out_target;
    logic          out_last;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    multi_vc_input_channel #(.NUM_VC(NV), .DEPTH(DEPTH), .PAYLOAD_W(PW), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .in_valid(in_valid), .in_vc(in_vc), .in_tag(in_tag), .in_payload(in_payload),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc),
        .out_tag(out_tag), .out_payload(out_payload), .out_target(out_target),
        .out_last(out_last), .err_count(err_count)
    );

    typedef struct packed {
        logic [1:0]    tag;
        logic [PW-1:0] pay;
        logic [2:0]    tgt;
    } flit_t;

    flit_t mq [NV][$];
    bit    m_open [NV];
    logic [2:0] m_tgt [NV];
    int    m_err;
    bit    own_v;
    int    own_vc;
    int    rr_last;
    bit    exp_valid;
    int    exp_vc;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_last(input logic [1:0] t);
        return (t == 2'd2) || (t == 2'd3);
    endfunction

    function automatic logic [2:0] ref_route(input logic [PW-1:0] p);
        int dx, dy, px, py;
        dx = int'(p[CW-1:0]);
        dy = int'(p[2*CW-1:CW]);
        px = int'(pos_x);
        py = int'(pos_y);
        if (dx > px) return 3'd1;
        if (dx < px) return 3'd2;
        if (dy > py) return 3'd3;
        if (dy < py) return 3'd4;
        return 3'd0;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            m_open[v] = 1'b0;
            m_tgt[v]  = 3'd0;
        end
        m_err   = 0;
        own_v   = 1'b0;
        own_vc  = 0;
        rr_last = NV - 1;
    endfunction

    // Which VC should be offering a flit right now, given queue contents and ownership.
    function automatic void compute_exp();
        int c;
        exp_valid = 1'b0;
        exp_vc    = 0;
        if (own_v) begin
            exp_vc    = own_vc;
            exp_valid = (mq[own_vc].size() > 0);
        end else begin
            for (int i = 1; i <= NV; i++) begin
                c = (rr_last + i) % NV;
                if (!exp_valid && mq[c].size() > 0) begin
                    exp_valid = 1'b1;
                    exp_vc    = c;
                end
            end
        end
    endfunction

    function automatic void model_edge();
        flit_t f;
        bit    acc, head;
        int    v;
        compute_exp();
        v   = int'(in_vc);
        acc = in_valid && (mq[v].size() < DEPTH);
        if (exp_valid) begin
            own_vc = exp_vc;
            if (out_ready) begin
                f       = mq[exp_vc].pop_front();
                rr_last = exp_vc;
                own_v   = !is_last(f.tag);
            end else begin
                own_v = 1'b1;
            end
        end
        if (acc) begin
            head = (in_tag == 2'd0) || (in_tag == 2'd3);
            if (head == m_open[v]) begin
                if (m_err < 255) m_err++;
            end else begin
                if (head) m_tgt[v] = ref_route(in_payload);
                f.tag = in_tag;
                f.pay = in_payload;
                f.tgt = m_tgt[v];
                mq[v].push_back(f);
                if (in_tag == 2'd0) m_open[v] = 1'b1;
                if (in_tag == 2'd2) m_open[v] = 1'b0;
            end
        end
    endfunction

    task automatic compare();
        logic [NV-1:0] er;
        flit_t f;
        compute_exp();
        for (int v = 0; v < NV; v++) er[v] = (mq[v].size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(er));
        check("err_count", 64'(err_count), 64'(m_err));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid && out_valid) begin
            f = mq[exp_vc][0];
            check("out_flit", 64'({out_vc, out_tag, out_target, out_last, out_payload}),
                  64'({VW'(exp_vc), f.tag, f.tgt, is_last(f.tag), f.pay}));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic push(input int v, input logic [1:0] t, input logic [PW-1:0] p);
        in_valid   = 1'b1;
        in_vc      = VW'(v);
        in_tag     = t;
        in_payload = p;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic do_reset(input logic [CW-1:0] px, input logic [CW-1:0] py);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        pos_x = px;
        pos_y = py;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check("post_rst_in_ready", 64'(in_ready), 64'h3);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        compare();
    endtask

    initial begin
        logic [PW-1:0] p;
        int v;
        model_reset();
        do_reset(4'd2, 4'd2);

        // Single-flit packet heading east.
        out_ready = 1'b1;
        push(0, 2'd3, 32'hA5A5_0015);
        check("t33_valid", 64'(out_valid), 64'd1);
        check("t33_target", 64'(out_target), 64'd1);
        check("t33_last", 64'(out_last), 64'd1);
        check("t33_vc", 64'(out_vc), 64'd0);
        tick();

        // Three-flit packet heading north on VC1.
        push(1, 2'd0, 32'h0000_0042);
        check("t34_start", 64'({out_target, out_last}), 64'({3'd3, 1'b0}));
        push(1, 2'd1, 32'hDEAD_BEEF);
        check("t34_body", 64'({out_target, out_last}), 64'({3'd3, 1'b0}));
        push(1, 2'd2, 32'h1234_5678);
        check("t34_tail", 64'({out_target, out_last}), 64'({3'd3, 1'b1}));
        tick();

        // Two buffered packets drain back to back without interleaving.
        out_ready = 1'b0;
        push(0, 2'd0, 32'h0000_0023);
        push(0, 2'd1, 32'h1111_1111);
        push(0, 2'd2, 32'h2222_2222);
        push(1, 2'd0, 32'h0000_0012);
        push(1, 2'd1, 32'h3333_3333);
        push(1, 2'd2, 32'h4444_4444);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t35_seq", 64'({out_valid, out_vc}), (k < 3) ? 64'h2 : 64'h3);
            tick();
        end
        check("t35_drained", 64'(out_valid), 64'd0);

        // Fill VC0, then free one slot.
        out_ready = 1'b0;
        push(0, 2'd0, 32'h0000_0022);
        for (int k = 0; k < 3; k++) push(0, 2'd1, $urandom());
        check("t36_full", 64'(in_ready), 64'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t36_pop", 64'(in_ready), 64'h3);
        push(0, 2'd2, $urandom());
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("t36_drained", 64'(out_valid), 64'd0);

        // Malformed BODY flits on a closed VC.
        push(0, 2'd1, $urandom());
        check("t37_err1", 64'(err_count), 64'd1);
        check("t37_noout", 64'(out_valid), 64'd0);
        for (int k = 0; k < 299; k++) push(0, 2'd1, $urandom());
        check("t37_sat", 64'(err_count), 64'd255);

        // Reset with a partial packet buffered.
        do_reset(4'd2, 4'd2);
        out_ready = 1'b0;
        push(1, 2'd0, 32'h0000_0033);
        for (int k = 0; k < 3; k++) push(1, 2'd1, $urandom());
        check("t38_buffered", 64'(out_valid), 64'd1);
        do_reset(4'd2, 4'd2);
        out_ready = 1'b1;
        push(1, 2'd1, $urandom());
        check("t38_fresh_err", 64'(err_count), 64'd1);
        for (int k = 0; k < 4; k++) tick();
        check("t38_no_stale", 64'(out_valid), 64'd0);

        // Randomized traffic, mostly well-formed packets.
        for (int r = 0; r < 2; r++) begin
            do_reset(CW'($urandom_range(0, 4)), CW'($urandom_range(0, 4)));
            for (int k = 0; k < 2500; k++) begin
                v          = int'($urandom_range(0, NV - 1));
                p          = $urandom();
                p[CW-1:0]  = CW'($urandom_range(0, 4));
                p[2*CW-1:CW] = CW'($urandom_range(0, 4));
                in_valid   = ($urandom_range(0, 99) < 60);
                in_vc      = VW'(v);
                in_payload = p;
                if ($urandom_range(0, 19) == 0)
                    in_tag = 2'($urandom_range(0, 3));
                else if (!m_open[v])
                    in_tag = $urandom_range(0, 1) ? 2'd0 : 2'd3;
                else
                    in_tag = ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd1;
                out_ready = ($urandom_range(0, 99) < 70);
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 20; k++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
